// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline: ALU opcodes, operand widths, forwarding
// and operand-select enums, and the ID/EX register bundle.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwdsel_t;

    typedef enum logic [1:0] {
        BSEL_RT    = 2'd0,
        BSEL_IMM   = 2'd1,
        BSEL_SHAMT = 2'd2,
        BSEL_LUI   = 2'd3
    } bsel_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        regbits_t wsel;
        regbits_t rs;
        regbits_t rt;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        logic [4:0] shamt;
        aluop_t   aluop;
        logic     asel;
        bsel_t    bsel;
    } idex_t;

    // EX/MEM is the younger producer, so it is checked first; r0 is hardwired.
    function automatic fwdsel_t fwd_pick(
        input regbits_t src,
        input logic     exm_valid,
        input logic     exm_regwr,
        input regbits_t exm_wsel,
        input logic     wb_regwr,
        input regbits_t wb_wsel
    );
        fwdsel_t sel;
        sel = FWD_REG;
        if (src != '0) begin
            if (exm_valid && exm_regwr && (exm_wsel == src)) begin
                sel = FWD_EXM;
            end else if (wb_regwr && (wb_wsel == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side, writeback-side and ALU-side signals of the ID/EX operand stage.
interface ex_operand_stage_if;
    import cpu_types_pkg::*;

    logic     stall;
    logic     flush;
    logic     id_valid;
    word_t    id_rdat1;
    word_t    id_rdat2;
    regbits_t id_rs;
    regbits_t id_rt;
    regbits_t id_wsel;
    word_t    id_imm;
    logic [4:0] id_shamt;
    aluop_t   id_aluop;
    logic     id_asel;
    logic [1:0] id_bsel;
    logic     id_regwr;
    logic     exm_regwr;
    logic     exm_valid;
    regbits_t exm_wsel;
    word_t    exm_dat;
    logic     wb_regwr;
    regbits_t wb_wsel;
    word_t    wb_dat;
    word_t    portA;
    word_t    portB;
    aluop_t   ALUOP;
    logic     ex_valid;
    logic     ex_regwr;
    regbits_t ex_wsel;
    word_t    ex_rtdat;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output stall, flush, id_valid, id_rdat1, id_rdat2, id_rs, id_rt, id_wsel,
               id_imm, id_shamt, id_aluop, id_asel, id_bsel, id_regwr,
               exm_regwr, exm_valid, exm_wsel, exm_dat, wb_regwr, wb_wsel, wb_dat,
        input  portA, portB, ALUOP, ex_valid, ex_regwr, ex_wsel, ex_rtdat, fwd_a, fwd_b
    );

    modport slave (
        input  stall, flush, id_valid, id_rdat1, id_rdat2, id_rs, id_rt, id_wsel,
               id_imm, id_shamt, id_aluop, id_asel, id_bsel, id_regwr,
               exm_regwr, exm_valid, exm_wsel, exm_dat, wb_regwr, wb_wsel, wb_dat,
        output portA, portB, ALUOP, ex_valid, ex_regwr, ex_wsel, ex_rtdat, fwd_a, fwd_b
    );

endinterface

// File: rtl/ex_operand_stage_forward_unit.sv
// Combinational RAW-hazard forwarding select for two source registers; also
// usable by the decode-stage branch comparator.
module forward_unit
    import cpu_types_pkg::*;
(
    input  regbits_t rs_i,
    input  regbits_t rt_i,
    input  logic     exm_valid_i,
    input  logic     exm_regwr_i,
    input  regbits_t exm_wsel_i,
    input  logic     wb_regwr_i,
    input  regbits_t wb_wsel_i,
    output fwdsel_t  fwd_rs_o,
    output fwdsel_t  fwd_rt_o
);

    regbits_t src [2];
    fwdsel_t  sel [2];

    assign src[0] = rs_i;
    assign src[1] = rt_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign sel[gi] = fwd_pick(src[gi], exm_valid_i, exm_regwr_i, exm_wsel_i,
                                      wb_regwr_i, wb_wsel_i);
        end
    endgenerate

    assign fwd_rs_o = sel[0];
    assign fwd_rt_o = sel[1];

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding
// the execute-stage ALU operands.
module ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    ex_operand_stage_if.slave  bus
);

    idex_t   stage_q;
    idex_t   stage_d;
    fwdsel_t sel_rs;
    fwdsel_t sel_rt;
    word_t   fwd_rs;
    word_t   fwd_rt;
    word_t   port_b;

    forward_unit u_forward_unit (
        .rs_i        (stage_q.rs),
        .rt_i        (stage_q.rt),
        .exm_valid_i (bus.exm_valid),
        .exm_regwr_i (bus.exm_regwr),
        .exm_wsel_i  (bus.exm_wsel),
        .wb_regwr_i  (bus.wb_regwr),
        .wb_wsel_i   (bus.wb_wsel),
        .fwd_rs_o    (sel_rs),
        .fwd_rt_o    (sel_rt)
    );

    always_comb begin
        case (sel_rs)
            FWD_EXM: fwd_rs = bus.exm_dat;
            FWD_WB:  fwd_rs = bus.wb_dat;
            default: fwd_rs = stage_q.rdat1;
        endcase
        case (sel_rt)
            FWD_EXM: fwd_rt = bus.exm_dat;
            FWD_WB:  fwd_rt = bus.wb_dat;
            default: fwd_rt = stage_q.rdat2;
        endcase
    end

    always_comb begin
        stage_d.valid = bus.id_valid;
        stage_d.regwr = bus.id_regwr;
        stage_d.wsel  = bus.id_wsel;
        stage_d.rs    = bus.id_rs;
        stage_d.rt    = bus.id_rt;
        stage_d.rdat1 = bus.id_rdat1;
        stage_d.rdat2 = bus.id_rdat2;
        stage_d.imm   = bus.id_imm;
        stage_d.shamt = bus.id_shamt;
        stage_d.aluop = bus.id_aluop;
        stage_d.asel  = bus.id_asel;
        stage_d.bsel  = bsel_t'(bus.id_bsel);
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.stall) begin
            // Capture forwarded operands so a producer retiring mid-stall is kept.
            stage_d       = stage_q;
            stage_d.rdat1 = fwd_rs;
            stage_d.rdat2 = fwd_rt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        case (stage_q.bsel)
            BSEL_IMM:   port_b = stage_q.imm;
            BSEL_SHAMT: port_b = {{(WORD_W-5){1'b0}}, stage_q.shamt};
            BSEL_LUI:   port_b = {stage_q.imm[15:0], 16'h0000};
            default:    port_b = fwd_rt;
        endcase
    end

    assign bus.portA    = stage_q.asel ? fwd_rt : fwd_rs;
    assign bus.portB    = port_b;
    assign bus.ALUOP    = stage_q.aluop;
    assign bus.ex_valid = stage_q.valid;
    assign bus.ex_regwr = stage_q.regwr;
    assign bus.ex_wsel  = stage_q.wsel;
    assign bus.ex_rtdat = fwd_rt;
    assign bus.fwd_a    = stage_q.valid ? sel_rs : FWD_REG;
    assign bus.fwd_b    = stage_q.valid ? sel_rt : FWD_REG;

endmodule
